// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, pixel type and colour-bar helper,
// used by the controller and by the picture generator.
package vga_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int H_TOTAL = SCREEN_W + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL = SCREEN_H + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [11:0] rgb_t;

    // Bar index bit 0 drives red, bit 1 green, bit 2 blue.
    function automatic rgb_t bar_colour(input logic [2:0] bar);
        return {{4{bar[0]}}, {4{bar[1]}}, {4{bar[2]}}};
    endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical raster counters; advance once per pixel strobe and wrap
// at end of line and end of frame.
module vga_timing_cnt
    import vga_pkg::*;
#(
    parameter int LINE_LEN    = H_TOTAL,
    parameter int FRAME_LINES = V_TOTAL,
    parameter int HW          = $clog2(LINE_LEN),
    parameter int VW          = $clog2(FRAME_LINES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt
);

    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
    localparam logic [VW-1:0] V_LAST = VW'(FRAME_LINES - 1);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing controller: sync generation, blanking and a one-pixel output
// register. Define VGA_TEST_PATTERN_EN to add test_sel and 8 colour bars.
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = SCREEN_W,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = SCREEN_H,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_sel,
`endif
    input  logic [11:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [11:0] vga_rgb,
    output logic        frame_start
);

    localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW          = $clog2(LINE_LEN);
    localparam int VW          = $clog2(FRAME_LINES);

    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_ACT = VW'(V_ACTIVE - 1);
`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0]    BAR_W     = 10'(H_ACTIVE / 8);
`endif

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          hs_n;
    logic          vs_n;
    logic          last_pixel;
    rgb_t          pixel;

    vga_timing_cnt #(
        .LINE_LEN    (LINE_LEN),
        .FRAME_LINES (FRAME_LINES),
        .HW          (HW),
        .VW          (VW)
    ) u_timing_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (pix_en),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt)
    );

    // NOTE: every output of this block is assigned on every path, so no latch.
    always_comb begin
        active     = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        pix_x      = active ? 10'(h_cnt) : '0;
        pix_y      = active ? 9'(v_cnt) : '0;
        hs_n       = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
        vs_n       = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
        last_pixel = (h_cnt == H_LAST) && (v_cnt == V_LAST_ACT);
`ifdef VGA_TEST_PATTERN_EN
        pixel      = test_sel ? bar_colour(3'(pix_x / BAR_W)) : rgb_in;
`else
        pixel      = rgb_in;
`endif
    end

    // rgb and syncs share one register stage so they stay pixel-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_rgb     <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && last_pixel;
            if (pix_en) begin
                vga_rgb <= active ? pixel : '0;
                vga_hs  <= ~hs_n;
                vga_vs  <= ~vs_n;
            end
        end
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a reduced-timing instance checked every clock against a
// raster model via a scoreboard, plus a full-size instance probed at boundaries.
module tb_vga_ctrl;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        rgb_mode = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_sel = 1'b0;
`endif
    logic [11:0] rgb_in, rgb_in_f, vga_rgb, vga_rgb_f;
    logic [9:0]  pix_x, pix_x_f;
    logic [8:0]  pix_y, pix_y_f;
    logic        vga_hs, vga_vs, frame_start;
    logic        vga_hs_f, vga_vs_f, frame_start_f;

    always #5 clk = ~clk;

    // Picture generator: coordinate pattern or a flat colour.
    assign rgb_in   = rgb_mode ? 12'hABC : {pix_y[3:0] ^ 4'h5, pix_x[7:0] ^ 8'h3C};
    assign rgb_in_f = rgb_mode ? 12'hABC : {pix_y_f[3:0] ^ 4'h5, pix_x_f[7:0] ^ 8'h3C};

    vga_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
`ifdef VGA_TEST_PATTERN_EN
        .test_sel(test_sel),
`endif
        .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb),
        .frame_start(frame_start)
    );

    vga_ctrl dut_full (
        .clk(clk), .rst(rst), .pix_en(pix_en),
`ifdef VGA_TEST_PATTERN_EN
        .test_sel(test_sel),
`endif
        .rgb_in(rgb_in_f), .pix_x(pix_x_f), .pix_y(pix_y_f),
        .vga_hs(vga_hs_f), .vga_vs(vga_vs_f), .vga_rgb(vga_rgb_f),
        .frame_start(frame_start_f)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } out_t;

    typedef struct {
        int          h;
        int          line;
        logic [11:0] rgb;
        logic        hs;
    } vec_t;

    out_t sb_q[$];
    out_t last_exp;
    int   m_h = 0, m_v = 0;
    bit   model_valid = 1'b0;
    int   full_edges = 0;
    int   checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_pix(input int h, input int v);
`ifdef VGA_TEST_PATTERN_EN
        if (test_sel) begin
            int bar = h / (HA / 8);
            return {bar[0] ? 4'hF : 4'h0, bar[1] ? 4'hF : 4'h0, bar[2] ? 4'hF : 4'h0};
        end
`endif
        return rgb_mode ? 12'hABC : {v[3:0] ^ 4'h5, h[7:0] ^ 8'h3C};
    endfunction

    // One clock: predict, push, clock, pop and compare.
    task automatic tick(input logic en, input logic r);
        out_t e, got;
        logic act;
        pix_en = en;
        rst    = r;
        act    = (m_h < HA) && (m_v < VA);
        if (model_valid) begin
            check("pix_x", 32'(pix_x), act ? m_h : 0);
            check("pix_y", 32'(pix_y), act ? m_v : 0);
        end
        if (r) begin
            e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
            m_h = 0;
            m_v = 0;
            model_valid = 1'b1;
            full_edges = 0;
        end else if (en) begin
            e.rgb = act ? model_pix(m_h, m_v) : 12'h000;
            e.hs  = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
            e.vs  = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
            e.fs  = (m_h == HT - 1) && (m_v == VA - 1);
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            full_edges++;
        end else begin
            e = last_exp;
            e.fs = 1'b0;
        end
        last_exp = e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("vga_rgb", 32'(vga_rgb), 32'(got.rgb));
        check("vga_hs", 32'(vga_hs), 32'(got.hs));
        check("vga_vs", 32'(vga_vs), 32'(got.vs));
        check("frame_start", 32'(frame_start), 32'(got.fs));
    endtask

    task automatic pixel(input int div);
        for (int k = 1; k < div; k++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    task automatic measure(input string tag, input int div);
        int guard = 0, period = 0, hs_low = 0, vs_low = 0, nz = 0;
        bit seen = 1'b0;
        while (!seen && guard < 2 * FRAME) begin
            pixel(div);
            guard++;
            seen = frame_start;
        end
        check({tag, "_sync"}, 32'(seen), 1);
        if (seen) begin
            seen = 1'b0;
            guard = 0;
            while (!seen && guard < 2 * FRAME) begin
                pixel(div);
                guard++;
                period++;
                hs_low += int'(!vga_hs);
                vs_low += int'(!vga_vs);
                nz     += int'(vga_rgb != 12'h000);
                seen = frame_start;
            end
            check({tag, "_period"}, period, FRAME);
            check({tag, "_hs_low"}, hs_low, HS * VT);
            check({tag, "_vs_low"}, vs_low, VS * HT);
            check({tag, "_nonzero"}, nz, HA * VA);
        end
    endtask

    initial begin
        vec_t tbl[9];
        int   guard;
        int   target;

        tbl[0] = '{h: 1,   line: 0, rgb: 12'hABC, hs: 1'b1};
        tbl[1] = '{h: 639, line: 0, rgb: 12'hABC, hs: 1'b1};
        tbl[2] = '{h: 640, line: 0, rgb: 12'h000, hs: 1'b1};
        tbl[3] = '{h: 655, line: 0, rgb: 12'h000, hs: 1'b1};
        tbl[4] = '{h: 656, line: 0, rgb: 12'h000, hs: 1'b0};
        tbl[5] = '{h: 751, line: 0, rgb: 12'h000, hs: 1'b0};
        tbl[6] = '{h: 752, line: 0, rgb: 12'h000, hs: 1'b1};
        tbl[7] = '{h: 799, line: 0, rgb: 12'h000, hs: 1'b1};
        tbl[8] = '{h: 0,   line: 1, rgb: 12'hABC, hs: 1'b1};

        // Case 1: reset three clocks with pix_en high, then first pixel.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        check("rst_hs_f", 32'(vga_hs_f), 1);
        check("rst_vs_f", 32'(vga_vs_f), 1);
        check("rst_rgb_f", 32'(vga_rgb_f), 0);
        check("rst_pix_x_f", 32'(pix_x_f), 0);
        check("rst_pix_y_f", 32'(pix_y_f), 0);
        tick(1'b1, 1'b0);
        check("first_rgb_f", 32'(vga_rgb_f), 32'h53C);

        // Full-size line boundaries with a flat colour.
        rgb_mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            target = tbl[i].line * 800 + tbl[i].h + 1;
            guard = 0;
            while (full_edges < target && guard < 2000) begin
                tick(1'b1, 1'b0);
                guard++;
            end
            check($sformatf("line_rgb_h%0d_v%0d", tbl[i].h, tbl[i].line), 32'(vga_rgb_f), 32'(tbl[i].rgb));
            check($sformatf("line_hs_h%0d_v%0d", tbl[i].h, tbl[i].line), 32'(vga_hs_f), 32'(tbl[i].hs));
            check("line_vs_f", 32'(vga_vs_f), 1);
            check("line_fs_f", 32'(frame_start_f), 0);
        end

        // Cases 2/3: free-running frame statistics; case 4: strobe every 4th clk.
        measure("div1", 1);
        measure("div4", 4);

        // Case 5: reset mid-frame (with pix_en low), restart from (0,0).
        guard = 0;
        while (!(m_h == 12 && m_v == 5) && guard < 2 * FRAME) begin
            pixel(1);
            guard++;
        end
        check("mid_reached", 32'(m_h == 12 && m_v == 5), 1);
        tick(1'b0, 1'b1);
        check("mid_pix_x", 32'(pix_x), 0);
        check("mid_pix_y", 32'(pix_y), 0);
        check("mid_hs", 32'(vga_hs), 1);
        guard = 0;
        target = 0;
        while (!frame_start && guard < 2 * FRAME) begin
            pixel(1);
            guard++;
            target++;
        end
        check("mid_fs_delay", target, HT * VA);

`ifdef VGA_TEST_PATTERN_EN
        // Case 6: colour bars on the full-size instance.
        test_sel = 1'b1;
        tick(1'b1, 1'b1);
        pixel(1);
        check("bar_x0", 32'(vga_rgb_f), 32'h000);
        while (full_edges < 86) pixel(1);
        check("bar_x85", 32'(vga_rgb_f), 32'hF00);
        while (full_edges < 161) pixel(1);
        check("bar_x160", 32'(vga_rgb_f), 32'h0F0);
        while (full_edges < 640) pixel(1);
        check("bar_x639", 32'(vga_rgb_f), 32'hFFF);
        test_sel = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
